// File: rtl/collapse_queue_if.sv
// Handshake bundle between dispatch (enqueue), scheduler (issue) and the collapsing queue.
// The master side drives requests and the slave side (the queue) returns occupancy and head entries.
interface collapse_queue_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int WIN   = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                 flush;
  logic                 enq_valid;
  logic [WIDTH-1:0]     enq_data;
  logic                 enq_ready;
  logic [WIN-1:0]       issue_mask;
  logic [WIN-1:0]       head_valid;
  logic [WIN*WIDTH-1:0] head_data;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;

  modport master (
    output flush, enq_valid, enq_data, issue_mask,
    input  enq_ready, head_valid, head_data, count, full, empty
  );

  modport slave (
    input  flush, enq_valid, enq_data, issue_mask,
    output enq_ready, head_valid, head_data, count, full, empty
  );
endinterface

// File: rtl/collapse_queue.sv
// Collapsing issue queue: any subset of the bottom WIN entries issues per cycle and the
// survivors compact toward index 0 in the same edge that accepts one new entry.
module collapse_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int WIN   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  collapse_queue_if.slave  q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_n [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_n;
  logic [CW-1:0]    removed;
  logic [CW-1:0]    shift_acc;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] eff;
  logic             full_s;
  logic             fire;

  // Occupancy is always contiguous from index 0, so valid bits follow directly from count.
  always_comb begin
    valid_q = '0;
    for (int i = 0; i < DEPTH; i++) valid_q[i] = (CW'(i) < count_q);
  end

  assign full_s = (count_q == CW'(DEPTH));
  assign fire   = q.enq_valid & ~full_s;
  assign eff    = DEPTH'(q.issue_mask) & valid_q;

  // shift_acc counts issued entries below i; above the window it equals the total removed.
  always_comb begin
    shift_acc = '0;
    for (int i = 0; i < DEPTH; i++) data_n[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (eff[i]) shift_acc = shift_acc + 1'b1;
        else        data_n[IW'(i) - IW'(shift_acc)] = data_q[i];
      end
    end
    removed = shift_acc;
    count_n = count_q - removed + CW'(fire);
    if (fire) data_n[IW'(count_q - removed)] = q.enq_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || q.flush) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      count_q <= count_n;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_n[i];
    end
  end

  assign q.count      = count_q;
  assign q.full       = full_s;
  assign q.empty      = (count_q == '0);
  assign q.enq_ready  = ~full_s;
  assign q.head_valid = valid_q[WIN-1:0];

  for (genvar g = 0; g < WIN; g++) begin : g_head
    assign q.head_data[g*WIDTH +: WIDTH] = data_q[g];
  end
endmodule

// File: doc/collapse_queue.md
Name: collapse_queue

Overview:
- Parametrised collapsing issue queue. Holds up to DEPTH entries, oldest at index 0. Entries always stay contiguous from 0 to count-1.
- Any subset of the bottom WIN entries may issue in one cycle. The queue compacts in the same clock edge and accepts one new entry per cycle.
- Successor to the fixed 3-window shift-amount logic. Per-entry shift computation, entry storage, occupancy tracking and enqueue handshake now live in one block.
- Sits between the dispatch stage (enqueue side) and the scheduler (issue_mask side).

Parameters:
- DEPTH, 8, number of entries; must be at least WIN and at least 2.
- WIDTH, 32, payload bits per entry.
- WIN, 3, number of bottom entries individually selectable for issue; 1 to DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous clear of all entries.
- enq_valid  input  1  enqueue request.
- enq_data  input  WIDTH  enqueue payload.
- enq_ready  output  1  queue can accept an entry this cycle.
- issue_mask  input  WIN  bit i set means entry i leaves this cycle.
- head_valid  output  WIN  bit i high means entry i is occupied.
- head_data  output  WIN*WIDTH  entry i payload at bits [i*WIDTH +: WIDTH].
- count  output  clog2(DEPTH+1)  number of occupied entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset: when rst_n is low at a rising edge, on the next cycle:
  - all entry valid bits are 0 and all payloads are 0;
  - count = 0, empty = 1, full = 0, enq_ready = 1, head_valid = 0, head_data = 0.
  - Reset overrides flush, enqueue and issue. Reset mid-operation discards all entries.
- Flush (rst_n high, flush high): same clearing as reset. Enqueue and issue are ignored that cycle.
- Effective issue:
  - eff[i] = issue_mask[i] AND valid[i]. Issue bits on empty entries are ignored.
  - removed = popcount(eff), range 0..WIN.
- Per-entry shift amount, computed combinationally each cycle:
  - for i < WIN: shift[i] = popcount(eff[i-1:0]); entry i is dropped if eff[i] is set.
  - for i >= WIN: shift[i] = removed.
  - A surviving entry i moves to index i - shift[i] at the clock edge.
  - Resulting order is the original age order with issued entries removed.
- Enqueue:
  - enq_ready = !full. It does not credit same-cycle issue.
  - fire = enq_valid AND enq_ready.
  - On fire, enq_data is written at index count - removed, in the same edge as the compaction.
  - enq_valid while enq_ready is low is ignored; there is no state change and the data is dropped.
- Next count = count - removed + fire. It never exceeds DEPTH and never underflows.
- Vacated slots at index count_next and above have their valid bit cleared. Their payload is don't-care; zero is preferred.
- Timing:
  - All outputs are registered-state derived, with no combinational path from issue_mask or enq_* to any output except enq_ready, which is a function of state only.
  - Latency: an entry enqueued at edge N is visible on head_* after edge N if its index is below WIN.
  - An issued entry disappears after the edge at which its issue_mask bit was sampled.
- Simultaneous events:
  - Enqueue and issue in the same cycle are both honoured.
  - Enqueue into an empty queue while issue_mask is nonzero: the issue is a no-op, and the entry lands at index 0.
  - Full queue with issue and enq_valid: issue is honoured, enqueue is refused (enq_ready is low).
- WIN = DEPTH is legal. In that case every entry is individually issuable and the rest group is empty.

Test Plan:
- Reset: hold rst_n low for 2 edges with enq_valid=1 -> count=0, empty=1, full=0, head_valid=3'b000, enq_ready=1.
- Fill: DEPTH=8, WIN=3, WIDTH=8; enqueue 0x11,0x12,0x13,0x14,0x15 on consecutive cycles with no issue -> count=5, head_valid=3'b111, heads 0x11/0x12/0x13.
- Middle issue: from the previous state, issue_mask=3'b010 -> next cycle count=4, heads 0x11/0x13/0x14, entry 3 = 0x15.
- Issue plus enqueue: from the previous state, issue_mask=3'b101 with enq 0x16 -> count=3, heads 0x13/0x15/0x16, head_valid=3'b111.
- Full and invalid-bit masking:
  - Fill to 8 -> full=1, enq_ready=0.
  - Offer enq 0xAA -> ignored, count stays 8.
  - issue_mask=3'b111 -> count=5.
  - Drain to count=1, then issue_mask=3'b110 -> count stays 1.
- Flush and reset priority:
  - With count=4, assert flush with enq_valid=1 -> count=0, empty=1.
  - Refill to 2, then pull rst_n low together with issue_mask=3'b011 -> count=0 and all head_data=0 on the next cycle.
